// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ABI register indices and the
// ID/EX pipeline register bundle used by the operand fetch stage.
package cpu_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned ADDR_WIDTH = 5;

   // ABI register indices
   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_A0   = 10;

   // ID/EX pipeline register contents
   typedef struct packed {
      logic [DATA_WIDTH-1:0] op1;
      logic [DATA_WIDTH-1:0] op2;
      logic [DATA_WIDTH-1:0] store_data;
      logic [ADDR_WIDTH-1:0] rd;
      logic                  alu_ctrl;
      logic                  reg_write;
      logic                  valid;
   } id_ex_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: 2**ADDR_WIDTH entries, entry 0 hard-wired to 0.
// Ports:
//   clk, rst             clock, asynchronous active-high reset (clears all entries)
//   wb_en/wb_addr/wb_data write-back port, written on rising clk
//   rs1/rs2 -> rd1/rd2   combinational reads with same-cycle write-back bypass
//   a0                   raw contents of entry A0_INDEX (no bypass)
module reg_file #(
   parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
   parameter int unsigned A0_INDEX   = cpu_pkg::REG_A0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wb_en,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   output logic [DATA_WIDTH-1:0] rd1,
   output logic [DATA_WIDTH-1:0] rd2,
   output logic [DATA_WIDTH-1:0] a0
);

   localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(A0_INDEX);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic                  wr_ok;

   // Writes to index 0 are discarded, so they never bypass either.
   assign wr_ok = wb_en && (wb_addr != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_ok) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rs1 != '0) begin
         rd1 = (wr_ok && (wb_addr == rs1)) ? wb_data : regs_q[rs1];
      end
      if (rs2 != '0) begin
         rd2 = (wr_ok && (wb_addr == rs2)) ? wb_data : regs_q[rs2];
      end
   end

   assign a0 = regs_q[A0_IDX];

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: reads two operands from the register file (with
// write-back bypass), selects register or immediate for operand 2, and holds
// the result in the ID/EX register with stall/flush/valid.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid, stall, flush           pipeline control (flush beats stall)
//   rs1, rs2, rd_in, imm, alu_src    decoded instruction fields
//   alu_ctrl_in, reg_write_in        control passed through to EX
//   wb_en, wb_addr, wb_data          register file write-back
//   ALUop1, ALUop2, ALUctrl          registered ALU inputs
//   store_data, rd_out, reg_write_out, out_valid  registered ID/EX state
//   a0                               debug view of register A0_INDEX
// DATA_WIDTH/ADDR_WIDTH must match cpu_pkg since id_ex_t is sized from it.
module operand_fetch_stage #(
   parameter int unsigned DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
   parameter int unsigned A0_INDEX   = cpu_pkg::REG_A0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic [ADDR_WIDTH-1:0] rd_in,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic                  alu_src,
   input  logic                  alu_ctrl_in,
   input  logic                  reg_write_in,
   input  logic                  wb_en,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic [DATA_WIDTH-1:0] ALUop1,
   output logic [DATA_WIDTH-1:0] ALUop2,
   output logic                  ALUctrl,
   output logic [DATA_WIDTH-1:0] store_data,
   output logic [ADDR_WIDTH-1:0] rd_out,
   output logic                  reg_write_out,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] a0
);

   import cpu_pkg::*;

   logic [DATA_WIDTH-1:0] rs1_val;
   logic [DATA_WIDTH-1:0] rs2_val;
   id_ex_t                id_ex_d;
   id_ex_t                id_ex_q;

   reg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .A0_INDEX   (A0_INDEX)
   ) u_reg_file (
      .clk     (clk),
      .rst     (rst),
      .wb_en   (wb_en),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rs1     (rs1),
      .rs2     (rs2),
      .rd1     (rs1_val),
      .rd2     (rs2_val),
      .a0      (a0)
   );

   always_comb begin
      id_ex_d = id_ex_q;
      if (flush) begin
         id_ex_d = '0;
      end else if (!stall) begin
         id_ex_d.op1        = rs1_val;
         id_ex_d.op2        = alu_src ? imm : rs2_val;
         id_ex_d.store_data = rs2_val;
         id_ex_d.rd         = rd_in;
         id_ex_d.alu_ctrl   = alu_ctrl_in;
         id_ex_d.reg_write  = reg_write_in & in_valid;
         id_ex_d.valid      = in_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign ALUop1        = id_ex_q.op1;
   assign ALUop2        = id_ex_q.op2;
   assign ALUctrl       = id_ex_q.alu_ctrl;
   assign store_data    = id_ex_q.store_data;
   assign rd_out        = id_ex_q.rd;
   assign reg_write_out = id_ex_q.reg_write;
   assign out_valid     = id_ex_q.valid;

endmodule

// File: tb/tb_operand_fetch_stage.sv
module tb_operand_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, stall, flush;
   logic [4:0]  rs1, rs2, rd_in;
   logic [31:0] imm;
   logic        alu_src, alu_ctrl_in, reg_write_in;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] ALUop1, ALUop2, store_data, a0;
   logic        ALUctrl, reg_write_out, out_valid;
   logic [4:0]  rd_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   operand_fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .stall         (stall),
      .flush         (flush),
      .rs1           (rs1),
      .rs2           (rs2),
      .rd_in         (rd_in),
      .imm           (imm),
      .alu_src       (alu_src),
      .alu_ctrl_in   (alu_ctrl_in),
      .reg_write_in  (reg_write_in),
      .wb_en         (wb_en),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .ALUop1        (ALUop1),
      .ALUop2        (ALUop2),
      .ALUctrl       (ALUctrl),
      .store_data    (store_data),
      .rd_out        (rd_out),
      .reg_write_out (reg_write_out),
      .out_valid     (out_valid),
      .a0            (a0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      step();
      wb_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      rs1 = '0; rs2 = '0; rd_in = '0; imm = '0;
      alu_src = 1'b0; alu_ctrl_in = 1'b0; reg_write_in = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      step(); step();
      rst = 1'b0;
      check("reset_valid", {31'b0, out_valid}, 32'h0);
      check("reset_op1", ALUop1, 32'h0);
      check("reset_a0", a0, 32'h0);

      // Write then read x5
      write_reg(5'd5, 32'hDEADBEEF);
      rs1 = 5'd5; rs2 = 5'd5; alu_src = 1'b0; in_valid = 1'b1;
      step();
      check("wr_rd_op1", ALUop1, 32'hDEADBEEF);
      check("wr_rd_op2", ALUop2, 32'hDEADBEEF);
      check("wr_rd_valid", {31'b0, out_valid}, 32'h1);

      // Same-cycle bypass on rs1
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h42; rs1 = 5'd7; rs2 = 5'd0;
      step();
      wb_en = 1'b0;
      check("bypass_op1", ALUop1, 32'h42);
      check("bypass_x0_op2", ALUop2, 32'h0);

      // x0 write is dropped and never bypassed
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF; rs1 = 5'd0;
      step();
      wb_en = 1'b0;
      check("x0_nobypass", ALUop1, 32'h0);
      step();
      check("x0_read", ALUop1, 32'h0);

      // Immediate path, store_data still carries rs2
      write_reg(5'd3, 32'd9);
      rs1 = 5'd5; rs2 = 5'd3; alu_src = 1'b1; imm = 32'hFFFFFFFC;
      alu_ctrl_in = 1'b1; rd_in = 5'd12; reg_write_in = 1'b1;
      step();
      check("imm_op2", ALUop2, 32'hFFFFFFFC);
      check("imm_store", store_data, 32'd9);
      check("imm_op1", ALUop1, 32'hDEADBEEF);
      check("imm_ctrl", {31'b0, ALUctrl}, 32'h1);
      check("imm_rd", {27'b0, rd_out}, 32'd12);
      check("imm_regwr", {31'b0, reg_write_out}, 32'h1);

      // Bubble: reg_write gated by in_valid
      in_valid = 1'b0;
      step();
      check("bubble_valid", {31'b0, out_valid}, 32'h0);
      check("bubble_regwr", {31'b0, reg_write_out}, 32'h0);

      // Capture, then stall two cycles with changing inputs
      in_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd5; alu_src = 1'b0; rd_in = 5'd4;
      alu_ctrl_in = 1'b0; reg_write_in = 1'b1;
      step();
      check("pre_stall_op1", ALUop1, 32'h42);
      check("pre_stall_a0", a0, 32'h0);
      stall = 1'b1; rs1 = 5'd3; rs2 = 5'd3; alu_src = 1'b1; imm = 32'h11;
      rd_in = 5'd9; alu_ctrl_in = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h55;
      step();
      wb_en = 1'b0;
      check("stall1_op1", ALUop1, 32'h42);
      check("stall1_op2", ALUop2, 32'hDEADBEEF);
      check("stall_a0", a0, 32'h55);
      rs1 = 5'd5; in_valid = 1'b0;
      step();
      check("stall2_op1", ALUop1, 32'h42);
      check("stall2_rd", {27'b0, rd_out}, 32'd4);
      check("stall2_ctrl", {31'b0, ALUctrl}, 32'h0);
      check("stall2_valid", {31'b0, out_valid}, 32'h1);

      // Flush beats stall
      flush = 1'b1; in_valid = 1'b1;
      step();
      check("flush_valid", {31'b0, out_valid}, 32'h0);
      check("flush_regwr", {31'b0, reg_write_out}, 32'h0);
      check("flush_op1", ALUop1, 32'h0);
      check("flush_ctrl", {31'b0, ALUctrl}, 32'h0);
      flush = 1'b0; stall = 1'b0;

      // Both read ports bypass the same write-back
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h77; rs1 = 5'd9; rs2 = 5'd9;
      alu_src = 1'b0;
      step();
      wb_en = 1'b0;
      check("dual_bypass_op1", ALUop1, 32'h77);
      check("dual_bypass_op2", ALUop2, 32'h77);

      // Asynchronous reset mid-operation
      write_reg(5'd6, 32'h1234);
      rs1 = 5'd6;
      step();
      check("pre_rst_op1", ALUop1, 32'h1234);
      stall = 1'b1; flush = 1'b1;
      rst = 1'b1;
      #1;
      check("arst_op1", ALUop1, 32'h0);
      check("arst_op2", ALUop2, 32'h0);
      check("arst_valid", {31'b0, out_valid}, 32'h0);
      check("arst_a0", a0, 32'h0);
      step();
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      step();
      check("post_rst_x6", ALUop1, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute stage that feeds the ALU.
- Holds the 32-entry architectural register file and reads two source operands with write-back bypass.
- Selects register or immediate for the second operand.
- Registers the operands and control in an ID/EX pipeline register with stall, flush and valid.
- Outputs drive the ALU's ALUop1, ALUop2 and ALUctrl inputs directly.

Parameters:
- DATA_WIDTH, 32, operand/register width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH entries)
- A0_INDEX, 10, register exposed on the a0 debug port

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode slot holds a real instruction
- stall  in  1  hold ID/EX register contents
- flush  in  1  insert bubble into ID/EX register
- rs1  in  ADDR_WIDTH  source register 1 index
- rs2  in  ADDR_WIDTH  source register 2 index
- rd_in  in  ADDR_WIDTH  destination register index
- imm  in  DATA_WIDTH  sign-extended immediate
- alu_src  in  1  0: op2 = rs2 value, 1: op2 = imm
- alu_ctrl_in  in  1  ALU control bit, passed through
- reg_write_in  in  1  instruction writes rd
- wb_en  in  1  write-back enable
- wb_addr  in  ADDR_WIDTH  write-back index
- wb_data  in  DATA_WIDTH  write-back data
- ALUop1  out  DATA_WIDTH  registered operand 1 (signed)
- ALUop2  out  DATA_WIDTH  registered operand 2 (signed)
- ALUctrl  out  1  registered ALU control
- store_data  out  DATA_WIDTH  registered rs2 value, regardless of alu_src
- rd_out  out  ADDR_WIDTH  registered destination index
- reg_write_out  out  1  registered write enable, gated by valid
- out_valid  out  1  ID/EX holds a real instruction
- a0  out  DATA_WIDTH  current contents of register A0_INDEX

Behaviour:
- Reset:
  - clk and rst are the only clock/reset.
  - rst asynchronous, active-high; on assertion every register-file entry and every registered output clear to 0 immediately.
  - a0 = 0 during reset.
  - Reset mid-stall or mid-flush overrides both.
- Register file:
  - Writes on rising clk when wb_en=1 and wb_addr!=0.
  - Entry 0 is never written and always reads 0.
- Reads are combinational, with bypass:
  - If wb_en=1, wb_addr==rsN and rsN!=0, the read value is wb_data (same-cycle write visible).
  - Otherwise the read value is the array entry.
- Operand 2: op2 = alu_src ? imm : rs2 value; store_data always captures the rs2 value.
- ID/EX update priority on each rising clk:
  - flush=1: out_valid=0, reg_write_out=0, ALUctrl=0, ALUop1/ALUop2/store_data/rd_out=0. Flush wins over stall.
  - else stall=1: all ID/EX outputs hold their previous values.
  - else: capture operands/control; out_valid=in_valid; reg_write_out=reg_write_in & in_valid.
- Write-back to the array proceeds every cycle independent of stall/flush.
- Latency: 1 cycle from decode inputs to ALU-facing outputs.
- a0:
  - Combinational read of entry A0_INDEX; no bypass.
  - Reflects a write on the cycle after the write edge.
- Arithmetic: none. Values pass unmodified; no extension is performed here, and imm arrives already DATA_WIDTH.
- Boundaries:
  - rs1==rs2==wb_addr: both ports bypass.
  - wb_addr=0 with wb_en=1: no effect, and no bypass of 0-index reads.
  - stall and in_valid both high: the new instruction is not captured; upstream must hold it.

Decomposition:
- Shared package cpu_pkg:
  - DATA_WIDTH and ADDR_WIDTH constants
  - ABI register index constants (ZERO=0, A0=10)
  - packed struct id_ex_t bundling op1, op2, store_data, rd, alu_ctrl, reg_write, valid
- One sub-module, reg_file:
  - Array, async reset, write port, two bypassed read ports, debug a0 port.
  - Top level instantiates it and implements the op2 mux plus the id_ex_t register.

Test Plan:
- Reset: assert rst mid-operation with ALUop1=0x1234 → all outputs and a0 read 0 immediately, before the next clk edge.
- Write-then-read: write x5=0xDEADBEEF, then next cycle rs1=5, alu_src=0, rs2=5 → after 1 cycle ALUop1=ALUop2=0xDEADBEEF.
- Bypass: same cycle wb_en=1, wb_addr=7, wb_data=0x00000042, rs1=7 → ALUop1=0x42 next cycle.
- x0: write wb_addr=0, wb_data=0xFFFFFFFF, then rs1=0 → ALUop1=0.
- Immediate path: alu_src=1, imm=0xFFFFFFFC, rs2=3 (x3=9) → ALUop2=0xFFFFFFFC, store_data=9.
- Stall/flush: capture valid instruction, then stall=1 for 2 cycles with changing inputs → outputs unchanged. Then flush=1 with stall=1 → out_valid=0, reg_write_out=0. A write to x10=0x55 during stall → a0=0x55 the next cycle.
